pkt_tx_framer: RTL
==================

// Module: pkt_tx_framer
// PURPOSE
//  Serialises one game-state snapshot (player X/Y position and flag byte) into a fixed 8-byte
//  packet and pushes it, byte by byte, into the UART transmit FIFO. Sits in the UART subsystem
//  as the write-side client of the TX FIFO (drives w_data/wr_uart, obeys tx_full), fed by the
//  game logic, which issues a one-cycle send request per snapshot.
// PARAMETERS
//  HEADER  8'hA5  start-of-packet byte, byte 0 of every packet
//  X_W     12     width of pos_x (1..16); zero-extended to 16 bits on the wire
//  Y_W     12     width of pos_y (1..16); zero-extended to 16 bits on the wire
// PORTS
//  clk       in   1    system clock
//  rst       in   1    synchronous, active-high reset
//  send_req  in   1    request to send one packet; sampled only in IDLE
//  pos_x     in   X_W  player X, captured on an accepted send_req
//  pos_y     in   Y_W  player Y, captured on an accepted send_req
//  flags     in   8    player status flags, captured on an accepted send_req
//  tx_full   in   1    UART TX FIFO full; no write may be issued while high
//  w_data    out  8    byte presented to the TX FIFO (registered)
//  wr_uart   out  1    FIFO write strobe, one byte per high cycle
//  busy      out  1    high from the cycle after an accepted send_req until packet end
//  pkt_done  out  1    one-cycle pulse after the last byte (checksum) is written
// BEHAVIOUR
//  - Packet, in order:
//    B0=HEADER, B1=seq, B2=x[15:8], B3=x[7:0], B4=y[15:8], B5=y[7:0], B6=flags,
//    B7=B1^B2^B3^B4^B5^B6 (XOR checksum, header excluded).
//  - seq: 8-bit counter, reset 0; increments by 1 when pkt_done pulses; wraps FF->00.
//  - FSM states IDLE, SEND, DONE. Reset -> IDLE; idx=0; w_data=8'h00; pkt_done=0.
//  - IDLE: send_req=1 captures pos_x/pos_y/flags/seq into an 8-byte buffer (checksum
//    computed at capture), sets idx=0 and w_data=B0, and moves to SEND. busy=0 in IDLE.
//  - SEND: wr_uart = !tx_full (combinational, same cycle). On a write cycle: idx+1 and
//    w_data<=B[idx+1]; if idx==7, go to DONE instead. With tx_full=1, hold idx and w_data.
//  - DONE: pkt_done=1 for exactly one cycle, seq+1, then IDLE. The next send_req is
//    accepted no earlier than the cycle after DONE.
//  - Best case: 1 capture cycle + 8 write cycles + 1 DONE cycle = 10 cycles per packet.
//  - wr_uart is 0 in IDLE and DONE, and is never high while tx_full=1.
//  - send_req while busy (SEND/DONE): ignored, not queued; captured data is not altered.
//  - Input changes after capture have no effect on the packet in flight.
//  - tx_full may toggle at any byte, including before B0 and before B7. No byte is
//    dropped or duplicated, and the byte order is preserved.
//  - rst mid-packet: immediate return to IDLE, wr_uart=0, seq=0, partial packet abandoned.
// TESTING
//  1. seq=0, x=12'h123, y=12'h456, flags=8'h81, tx_full=0 -> wr_uart high 8 consecutive
//     cycles carrying A5,00,01,23,04,56,81,F1; pkt_done one cycle later.
//  2. Same stimulus with tx_full=1 for 5 cycles before B3 -> stall with w_data held at 23,
//     no wr_uart; the resumed byte stream is identical to test 1.
//  3. Three back-to-back packets (send_req re-raised in IDLE) -> seq bytes 00,01,02 and
//     the checksum updates accordingly; pkt_done count = 3.
//  4. send_req pulsed every cycle during SEND -> exactly one packet emitted; a new packet
//     starts only after pkt_done.
//  5. rst asserted after B4 is written -> next cycle wr_uart=0, busy=0; the next packet
//     starts with A5,00.
//  6. 256 packets -> seq wraps FF->00; wr_uart & tx_full never both high (assertion).

Source files
------------

// File: rtl/pkt_tx_framer_if.sv
// pkt_tx_framer_if: snapshot request from the game logic and TX FIFO write-side signals
interface pkt_tx_framer_if #(parameter int X_W = 12, parameter int Y_W = 12);
  logic send_req;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic [7:0] flags;
  logic tx_full;
  logic [7:0] w_data;
  logic wr_uart;
  logic busy;
  logic pkt_done;
  modport master(input send_req, pos_x, pos_y, flags, tx_full, output w_data, wr_uart, busy, pkt_done);
  modport slave(output send_req, pos_x, pos_y, flags, tx_full, input w_data, wr_uart, busy, pkt_done);
endinterface

// File: rtl/pkt_tx_framer.sv
// pkt_tx_framer: serialises a position/flags snapshot into an 8-byte packet for the UART TX FIFO
module pkt_tx_framer #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int X_W = 12,
  parameter int Y_W = 12
) (
  input logic clk,
  input logic rst,
  pkt_tx_framer_if.master bus
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] w_data_q, w_data_d, seq_q, seq_d;
  logic [7:0][7:0] buf_q, buf_d, cap;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;
  logic [15:0] x16, y16;
  logic wr;
  assign px = bus.pos_x;
  assign py = bus.pos_y;
  assign x16 = 16'(px);
  assign y16 = 16'(py);
  // whole packet, checksum included, is frozen at capture so later input changes cannot leak in
  assign cap = {seq_q ^ x16[15:8] ^ x16[7:0] ^ y16[15:8] ^ y16[7:0] ^ bus.flags,
                bus.flags, y16[7:0], y16[15:8], x16[7:0], x16[15:8], seq_q, HEADER};
  assign wr = (state_q == SEND) && !bus.tx_full;
  assign bus.wr_uart = wr;
  assign bus.busy = state_q != IDLE;
  assign bus.pkt_done = state_q == DONE;
  assign bus.w_data = w_data_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    w_data_d = w_data_q;
    seq_d = seq_q;
    buf_d = buf_q;
    case (state_q)
      IDLE: if (bus.send_req) begin
        buf_d = cap;
        idx_d = 3'd0;
        w_data_d = HEADER;
        state_d = SEND;
      end
      SEND: if (wr) begin
        state_d = (idx_q == 3'd7) ? DONE : SEND;
        idx_d = idx_q + 3'd1;
        w_data_d = (idx_q == 3'd7) ? w_data_q : buf_q[idx_q + 3'd1];
      end
      DONE: begin
        seq_d = seq_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= 3'd0;
      w_data_q <= 8'h00;
      seq_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      w_data_q <= w_data_d;
      seq_q <= seq_d;
    end
    buf_q <= buf_d;
  end
endmodule
